sub_csel16_pipe: RTL and testbench

//  Pipelined 16-bit carry-select subtractor: diff = a - b - bin.
//  Two-stage valid/ready pipeline, full throughput. Stage 1 computes the low half and both

---
 rtl/sub_csel16_pipe.sv | 98 +++++++++
 tb/tb_sub_csel16_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_csel16_pipe.sv
// Two-stage valid/ready carry-select subtractor: diff = a - b - bin, with block
// borrow-generate/propagate and signed overflow for composing wider subtractors.
module sub_csel16_pipe #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         bgen,
  output logic         bprop,
  output logic         ovf
);
  localparam int M = N / 2;

  logic         s1_valid, s2_valid;
  logic         adv1, adv2;
  logic [M-1:0] a_lo, b_lo, a_hi, b_hi;
  logic [M-1:0] bin_ext, one_ext;

  logic [M-1:0] dlo, dh0, dh1;
  logic         gl, pl, gh, ph;
  logic         bin_r, amsb, bmsb;

  logic         sel;
  logic [M-1:0] dhi;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  assign a_lo    = a[M-1:0];
  assign b_lo    = b[M-1:0];
  assign a_hi    = a[N-1:M];
  assign b_hi    = b[N-1:M];
  assign bin_ext = {{(M-1){1'b0}}, bin};
  assign one_ext = {{(M-1){1'b0}}, 1'b1};

  // Stage 1: low half plus both high-half candidates, one per possible low borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      dlo      <= '0;
      dh0      <= '0;
      dh1      <= '0;
      gl       <= 1'b0;
      pl       <= 1'b0;
      gh       <= 1'b0;
      ph       <= 1'b0;
      bin_r    <= 1'b0;
      amsb     <= 1'b0;
      bmsb     <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      dlo      <= a_lo - b_lo - bin_ext;
      dh0      <= a_hi - b_hi;
      dh1      <= a_hi - b_hi - one_ext;
      gl       <= a_lo < b_lo;
      pl       <= a_lo == b_lo;
      gh       <= a_hi < b_hi;
      ph       <= a_hi == b_hi;
      bin_r    <= bin;
      amsb     <= a[N-1];
      bmsb     <= b[N-1];
    end
  end

  // Low-half borrow rebuilt from generate/propagate; identical to the low-half borrow-out.
  assign sel = gl | (pl & bin_r);
  assign dhi = sel ? dh1 : dh0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      bgen     <= 1'b0;
      bprop    <= 1'b0;
      ovf      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      diff     <= {dhi, dlo};
      bout     <= gh | (ph & gl) | (ph & pl & bin_r);
      bgen     <= gh | (ph & gl);
      bprop    <= ph & pl;
      ovf      <= (amsb ^ bmsb) & (dhi[M-1] ^ amsb);
    end
  end

endmodule

// File: tb/tb_sub_csel16_pipe.sv
// Self-checking bench for sub_csel16_pipe: directed corner cases, backpressure,
// mid-flight reset and a long random run against an arithmetic reference model.
module tb_sub_csel16_pipe;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        bgen;
    logic        bprop;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout, bgen, bprop, ovf;

  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  res_t        sb[$];
  logic        use_dir = 1'b0;
  res_t        dir_exp;
  logic        held_ok = 1'b0;
  res_t        held;

  sub_csel16_pipe #(.N(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .bgen     (bgen),
    .bprop    (bprop),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Reference: 17-bit unsigned subtraction for diff/borrow, integer range test for ovf.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    res_t        r;
    logic [16:0] w;
    int          sr;
    w       = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    r.diff  = w[15:0];
    r.bout  = w[16];
    r.bgen  = x < y;
    r.bprop = x == y;
    sr      = int'($signed(x)) - int'($signed(y)) - (bi ? 1 : 0);
    r.ovf   = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  function automatic res_t mk(input logic [15:0] d, input logic bo, input logic bg,
                              input logic bp, input logic ov);
    res_t r;
    r.diff = d; r.bout = bo; r.bgen = bg; r.bprop = bp; r.ovf = ov;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, then advance past the rising edge.
  task automatic step(input int eir = -1, input int eov = -1);
    res_t e;
    @(negedge clk);
    if (eir >= 0) chk("in_ready", {31'd0, in_ready}, eir);
    if (eov >= 0) chk("out_valid", {31'd0, out_valid}, eov);
    if (held_ok && !rst) begin
      chk("hold_diff", {16'd0, diff}, {16'd0, held.diff});
      chk("hold_flags", {28'd0, bout, bgen, bprop, ovf},
          {28'd0, held.bout, held.bgen, held.bprop, held.ovf});
    end
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("diff", {16'd0, diff}, {16'd0, e.diff});
        chk("bout", {31'd0, bout}, {31'd0, e.bout});
        chk("bgen", {31'd0, bgen}, {31'd0, e.bgen});
        chk("bprop", {31'd0, bprop}, {31'd0, e.bprop});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
    if (!rst && in_valid && in_ready) begin
      sb.push_back(use_dir ? dir_exp : model(a, b, bin));
      accepted++;
    end
    if (rst) sb.delete();
    held_ok = !rst && out_valid && !out_ready;
    held    = mk(diff, bout, bgen, bprop, ovf);
    @(posedge clk);
    #1;
  endtask

  // Single set into an empty pipe with out_ready=1; result must appear exactly 2 cycles later.
  task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic bi,
                          input res_t exp);
    use_dir  = 1'b1;
    dir_exp  = exp;
    a        = x;
    b        = y;
    bin      = bi;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step(1, 0);
    in_valid = 1'b0;
    step(-1, 0);
    step(-1, 1);
    use_dir  = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_fields"}, {12'd0, diff, bout, bgen, bprop, ovf}, 32'd0);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corner[4];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return 16'($urandom());
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    step(1, 0);

    directed(16'h1234, 16'h0234, 1'b0, mk(16'h1000, 1'b0, 1'b0, 1'b0, 1'b0));
    directed(16'h0100, 16'h0001, 1'b0, mk(16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0));
    directed(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0));
    directed(16'h5555, 16'h5555, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0));
    directed(16'h5555, 16'h5555, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
    directed(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1));
    directed(16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
    step(-1, 0);

    // Backpressure: two sets fill the pipe, the third is refused while outputs hold.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h0010; b = 16'h0003; bin = 1'b0; step(1, 0);
    a = 16'h0300; b = 16'h0400; bin = 1'b1; step(1, 0);
    a = 16'hA5A5; b = 16'h5A5A; bin = 1'b1;
    step(0, 1);
    step(0, 1);
    step(0, 1);
    out_ready = 1'b1;
    step(1, 1);
    in_valid = 1'b0;
    step(-1, 1);
    step(-1, 1);
    step(-1, 0);
    chk("bp_drained", sb.size(), 32'd0);

    // Reset one cycle after accepting two sets: neither may ever be emitted.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h1111; b = 16'h0101; bin = 1'b0; step(1, 0);
    a = 16'h2222; b = 16'h3333; bin = 1'b1; step(1, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    chk_zero_outputs("midreset");
    out_ready = 1'b1;
    step(1, 0);
    step(1, 0);
    a = 16'hC000; b = 16'h4001; bin = 1'b1;
    in_valid = 1'b1;
    step(1, 0);
    in_valid = 1'b0;
    step(-1, 0);
    step(-1, 1);
    step(-1, 0);

    // Random traffic with random backpressure, checked in order by the scoreboard.
    accepted = 0;
    for (int i = 0; i < 60000 && accepted < 10000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a   = pick();
      b   = pick();
      bin = 1'($urandom_range(0, 1));
      step();
    end
    chk("random_accepted", accepted, 32'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("final_drained", sb.size(), 32'd0);
    chk("final_idle", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
